// File: rtl/psum_accum_ctrl.sv
// Partial-sum accumulation controller: runs the 16-lane adder tree over groups
// of input vectors, seeds each group with a bias and streams results out.
module adder_tree_16 #(
    parameter int DWIDTH = 16
) (
    input  logic [DWIDTH*16-1:0] data_i,
    output logic [DWIDTH-1:0]    sum_o
);
    logic [DWIDTH-1:0] l0 [16];
    logic [DWIDTH-1:0] l1 [8];
    logic [DWIDTH-1:0] l2 [4];
    logic [DWIDTH-1:0] l3 [2];

    // Balanced four-level tree; every node wraps modulo 2^DWIDTH.
    for (genvar k = 0; k < 16; k++) begin : g_l0
        assign l0[k] = data_i[DWIDTH*k +: DWIDTH];
    end
    for (genvar k = 0; k < 8; k++) begin : g_l1
        assign l1[k] = l0[2*k] + l0[2*k+1];
    end
    for (genvar k = 0; k < 4; k++) begin : g_l2
        assign l2[k] = l1[2*k] + l1[2*k+1];
    end
    for (genvar k = 0; k < 2; k++) begin : g_l3
        assign l3[k] = l2[2*k] + l2[2*k+1];
    end
    assign sum_o = l3[0] + l3[1];
endmodule

module psum_accum_ctrl #(
    parameter int DWIDTH = 16,
    parameter int PASS_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PASS_W-1:0]    cfg_passes,
    input  logic [OUT_W-1:0]     cfg_outputs,
    input  logic [DWIDTH-1:0]    cfg_bias,
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DWIDTH*16-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DWIDTH-1:0]    out_data
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PASS_W-1:0] pcnt_q, pcnt_d, passes_q, passes_d;
    logic [OUT_W-1:0]  ocnt_q, ocnt_d, outputs_q, outputs_d;
    logic [DWIDTH-1:0] acc_q, acc_d, bias_q, bias_d;
    logic              done_q, done_d;
    logic [DWIDTH-1:0] tree_sum;

    adder_tree_16 #(.DWIDTH(DWIDTH)) u_tree (
        .data_i (in_data),
        .sum_o  (tree_sum)
    );

    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        ocnt_d    = ocnt_q;
        acc_d     = acc_q;
        passes_d  = passes_q;
        outputs_d = outputs_q;
        bias_d    = bias_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Zero counts are promoted to one so every job makes progress.
                    passes_d  = (cfg_passes  == '0) ? PASS_W'(1) : cfg_passes;
                    outputs_d = (cfg_outputs == '0) ? OUT_W'(1)  : cfg_outputs;
                    bias_d    = cfg_bias;
                    pcnt_d    = '0;
                    ocnt_d    = '0;
                    state_d   = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    acc_d = ((pcnt_q == '0) ? bias_q : acc_q) + tree_sum;
                    if (pcnt_q == passes_q - PASS_W'(1)) begin
                        pcnt_d  = '0;
                        state_d = S_OUT;
                    end else begin
                        pcnt_d = pcnt_q + PASS_W'(1);
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    ocnt_d = ocnt_q + OUT_W'(1);
                    if (ocnt_q == outputs_q - OUT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pcnt_q    <= '0;
            ocnt_q    <= '0;
            acc_q     <= '0;
            passes_q  <= '0;
            outputs_q <= '0;
            bias_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            ocnt_q    <= ocnt_d;
            acc_q     <= acc_d;
            passes_q  <= passes_d;
            outputs_q <= outputs_d;
            bias_q    <= bias_d;
            done_q    <= done_d;
        end
    end

    // acc is frozen outside ACCUM, so out_data stays stable under back-pressure.
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = acc_q;
endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Directed bench for psum_accum_ctrl; expected values are hand-computed sums.
module tb_psum_accum_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   cfg_passes = '0;
    logic [15:0]  cfg_outputs = '0;
    logic [15:0]  cfg_bias = '0;
    logic         busy, done, in_ready, out_valid;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [255:0] in_data = '0;
    logic [15:0]  out_data;

    int n_chk  = 0;
    int n_fail = 0;
    int n_cons = 0;
    int base;

    always #5 clk = ~clk;

    psum_accum_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_passes(cfg_passes), .cfg_outputs(cfg_outputs), .cfg_bias(cfg_bias),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always @(posedge clk) if (in_valid && in_ready) n_cons <= n_cons + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // All tasks are entered and left on a falling edge.
    task automatic start_job(input logic [7:0] p, input logic [15:0] o, input logic [15:0] b);
        start = 1'b1; cfg_passes = p; cfg_outputs = o; cfg_bias = b;
        @(negedge clk);
        start = 1'b0; cfg_passes = '0; cfg_outputs = '0; cfg_bias = '0;
    endtask

    task automatic send(input logic [15:0] v);
        in_valid = 1'b1;
        in_data  = {16{v}};
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic take(input string tag, input logic [15:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
        chk(tag, out_data, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset pulse between clock edges
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        #1 rst = 1'b0;
        @(negedge clk);

        // Single pass: 5 + 16*1 = 21
        start_job(8'd1, 16'd1, 16'd5);
        chk("sp_in_ready", in_ready, 1);
        chk("sp_busy", busy, 1);
        send(16'd1);
        chk("sp_out_valid", out_valid, 1);
        take("sp_data", 16'd21);
        chk("sp_done", done, 1);
        chk("sp_busy_at_done", busy, 0);

        // Start in the done cycle; multi-pass with gaps: 16*(1+2+3) = 96
        base = n_cons;
        start_job(8'd3, 16'd1, 16'd0);
        chk("mp_done_clear", done, 0);
        send(16'd1);
        @(negedge clk);
        chk("mp_gap_in_ready", in_ready, 1);
        send(16'd2);
        @(negedge clk);
        send(16'd3);
        chk("mp_out_valid", out_valid, 1);
        in_valid = 1'b1; in_data = {16{16'd9}};
        @(negedge clk);
        in_valid = 1'b0;
        chk("mp_consumed", n_cons - base, 3);
        take("mp_data", 16'd96);
        chk("mp_done", done, 1);

        // Back-pressure, two outputs: 7+32 = 39, then fresh seed 7+16 = 23
        start_job(8'd1, 16'd2, 16'd7);
        send(16'd2);
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold_data", out_data, 16'd39);
            chk("bp_hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        take("bp_data0", 16'd39);
        chk("bp_mid_done", done, 0);
        chk("bp_back_accum", in_ready, 1);
        send(16'd1);
        take("bp_data1", 16'd23);
        chk("bp_done", done, 1);

        // Wrap: 16 * 0xFFFF = 0xFFF0 mod 2^16
        start_job(8'd1, 16'd1, 16'd0);
        send(16'hFFFF);
        take("wrap_data", 16'hFFF0);
        @(negedge clk);

        // Degenerate 0/0 config behaves as 1/1: 3 + 16 = 19
        start_job(8'd0, 16'd0, 16'd3);
        send(16'd1);
        chk("deg_out_valid", out_valid, 1);
        take("deg_data", 16'd19);
        chk("deg_done", done, 1);
        @(negedge clk);

        // Busy-time start ignored: stays p=2, o=1, bias=10 -> 10+32 = 42
        start_job(8'd2, 16'd1, 16'd10);
        start_job(8'd5, 16'd3, 16'd100);
        send(16'd1);
        chk("ign_still_accum", out_valid, 0);
        send(16'd1);
        take("ign_data", 16'd42);
        chk("ign_done", done, 1);
        @(negedge clk);

        // Abort in OUT: asynchronous reset, no done afterwards
        start_job(8'd1, 16'd1, 16'd4);
        send(16'd1);
        chk("ab_in_out", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("ab_busy", busy, 0);
        chk("ab_out_valid", out_valid, 0);
        chk("ab_out_data", out_data, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ab_no_done0", done, 0);
        @(negedge clk);
        chk("ab_no_done1", done, 0);
        start_job(8'd1, 16'd1, 16'd0);
        chk("ab_restart", in_ready, 1);
        send(16'd2);
        take("ab_data", 16'd32);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
